// File: rtl/decode_pipe_if.sv
// rtl/decode_pipe_if.sv - decode stage handshake, write-back and decoded-bundle signals
// slave is the decoder's view; master is the fetch/execute side driving it.
interface decode_pipe_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       instr;
  logic              flush;
  logic              wb_reg_write;
  logic [3:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_opcode;
  logic [3:0]        out_rd;
  logic [3:0]        out_rs1;
  logic [3:0]        out_rs2;
  logic [DATA_W-1:0] out_rs1_data;
  logic [DATA_W-1:0] out_rs2_data;
  logic [DATA_W-1:0] out_imm;
  logic              out_reg_write;
  logic              out_alu_src;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_mem_to_reg;
  logic              out_branch;
  logic              out_branch_ne;
  logic              out_halt;
  logic [3:0]        out_alu_op;
  logic              halted;

  modport slave (
    input  in_valid, instr, flush, wb_reg_write, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
           out_rs1_data, out_rs2_data, out_imm, out_reg_write, out_alu_src,
           out_mem_read, out_mem_write, out_mem_to_reg, out_branch,
           out_branch_ne, out_halt, out_alu_op, halted
  );

  modport master (
    output in_valid, instr, flush, wb_reg_write, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
           out_rs1_data, out_rs2_data, out_imm, out_reg_write, out_alu_src,
           out_mem_read, out_mem_write, out_mem_to_reg, out_branch,
           out_branch_ne, out_halt, out_alu_op, halted
  );
endinterface

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - instruction decode stage with register file, load-use stall and halt
// The bus interface DATA_W must equal this module's DATA_W.
module decode_pipe #(
  parameter int DATA_W = 16,
  parameter int NREG   = 16,
  parameter int IMM_W  = 4
) (
  input  logic          clk,
  input  logic          rst,
  decode_pipe_if.slave  bus
);
  localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4, OP_SLT = 4'h5, OP_ADDI = 4'h6, OP_LW = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8, OP_BEQ = 4'h9, OP_BNE = 4'hA, OP_HALT = 4'hF;
  localparam logic [3:0] ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2, ALU_OR = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4, ALU_SLT = 4'h5;

  typedef struct packed {
    logic [3:0]        opcode;
    logic [3:0]        rd;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic              reg_write;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              branch;
    logic              branch_ne;
    logic              halt;
    logic [3:0]        alu_op;
  } bundle_t;

  // Sized to the full 4-bit address space; entries at or above NREG are never written.
  logic [DATA_W-1:0] r_regs [16];
  bundle_t           r_out;
  logic              r_out_valid;
  logic              r_halted;

  logic [3:0]        w_rs1, w_rs2;
  logic              w_wb_ok, w_hazard, w_in_ready, w_accept;
  logic [DATA_W-1:0] w_rs1_data, w_rs2_data;
  bundle_t           w_dec;

  assign w_rs1   = bus.instr[7:4];
  assign w_rs2   = bus.instr[3:0];
  assign w_wb_ok = bus.wb_reg_write && (bus.wb_rd != 4'd0) && (32'(bus.wb_rd) < NREG);

  always_comb begin
    w_rs1_data = '0;
    w_rs2_data = '0;
    if (w_rs1 != 4'd0 && 32'(w_rs1) < NREG)
      w_rs1_data = (w_wb_ok && w_rs1 == bus.wb_rd) ? bus.wb_data : r_regs[w_rs1];
    if (w_rs2 != 4'd0 && 32'(w_rs2) < NREG)
      w_rs2_data = (w_wb_ok && w_rs2 == bus.wb_rd) ? bus.wb_data : r_regs[w_rs2];
  end

  always_comb begin
    w_dec          = '0;
    w_dec.opcode   = bus.instr[15:12];
    w_dec.rd       = bus.instr[11:8];
    w_dec.rs1      = w_rs1;
    w_dec.rs2      = w_rs2;
    w_dec.rs1_data = w_rs1_data;
    w_dec.rs2_data = w_rs2_data;
    w_dec.imm      = DATA_W'($signed(bus.instr[IMM_W-1:0]));
    w_dec.alu_op   = ALU_ADD;
    case (bus.instr[15:12])
      OP_ADD:  w_dec.reg_write = 1'b1;
      OP_SUB:  begin w_dec.reg_write = 1'b1; w_dec.alu_op = ALU_SUB; end
      OP_AND:  begin w_dec.reg_write = 1'b1; w_dec.alu_op = ALU_AND; end
      OP_OR:   begin w_dec.reg_write = 1'b1; w_dec.alu_op = ALU_OR;  end
      OP_XOR:  begin w_dec.reg_write = 1'b1; w_dec.alu_op = ALU_XOR; end
      OP_SLT:  begin w_dec.reg_write = 1'b1; w_dec.alu_op = ALU_SLT; end
      OP_ADDI: begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; end
      OP_LW: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.mem_read   = 1'b1;
        w_dec.mem_to_reg = 1'b1;
      end
      OP_SW:   begin w_dec.alu_src = 1'b1; w_dec.mem_write = 1'b1; end
      OP_BEQ:  begin w_dec.branch = 1'b1; w_dec.alu_op = ALU_SUB; end
      OP_BNE: begin
        w_dec.branch    = 1'b1;
        w_dec.branch_ne = 1'b1;
        w_dec.alu_op    = ALU_SUB;
      end
      OP_HALT: w_dec.halt = 1'b1;
      default: ;
    endcase
  end

  // Load-use: the load in the output register cannot forward to the instruction behind it.
  assign w_hazard   = r_out_valid && r_out.mem_read && (r_out.rd != 4'd0) &&
                      ((r_out.rd == w_rs1) || (r_out.rd == w_rs2));
  assign w_in_ready = !rst && !r_halted && !bus.flush && !w_hazard &&
                      (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else if (w_wb_ok) begin
      r_regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_halted    <= 1'b0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out       <= w_dec;
      if (w_dec.halt) r_halted <= 1'b1;
    end else if (bus.out_ready || !r_out_valid) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = r_out_valid;
  assign bus.out_opcode     = r_out.opcode;
  assign bus.out_rd         = r_out.rd;
  assign bus.out_rs1        = r_out.rs1;
  assign bus.out_rs2        = r_out.rs2;
  assign bus.out_rs1_data   = r_out.rs1_data;
  assign bus.out_rs2_data   = r_out.rs2_data;
  assign bus.out_imm        = r_out.imm;
  assign bus.out_reg_write  = r_out.reg_write;
  assign bus.out_alu_src    = r_out.alu_src;
  assign bus.out_mem_read   = r_out.mem_read;
  assign bus.out_mem_write  = r_out.mem_write;
  assign bus.out_mem_to_reg = r_out.mem_to_reg;
  assign bus.out_branch     = r_out.branch;
  assign bus.out_branch_ne  = r_out.branch_ne;
  assign bus.out_halt       = r_out.halt;
  assign bus.out_alu_op     = r_out.alu_op;
  assign bus.halted         = r_halted;
endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter DATA_W, default 16, datapath and register width (8..32).
REQ-002 Parameter NREG, default 16, number of architectural registers (2..16); register addresses are 4 bits regardless of NREG.
REQ-003 Parameter IMM_W, default 4, immediate field width taken from instr[IMM_W-1:0] (1..8).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port in_valid  input  1  IF presents instr.
REQ-007 Port in_ready  output  1  block accepts instr this cycle.
REQ-008 Port instr  input  16  instruction: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2.
REQ-009 Port flush  input  1  discard registered output (branch redirect).
REQ-010 Port wb_reg_write, wb_rd, wb_data  input  1/4/DATA_W  write-back port.
REQ-011 Port out_valid  output  1  decoded bundle valid to EX.
REQ-012 Port out_ready  input  1  EX accepts bundle.
REQ-013 Ports out_opcode, out_rd, out_rs1, out_rs2  output  4 each  registered fields.
REQ-014 Ports out_rs1_data, out_rs2_data, out_imm  output  DATA_W each  registered operands.
REQ-015 Ports out_reg_write, out_alu_src, out_mem_read, out_mem_write, out_mem_to_reg, out_branch, out_branch_ne, out_halt  output  1 each; out_alu_op output 4.
REQ-016 Port halted  output  1  HALT accepted; decoder frozen.

Function
REQ-017 Opcode and ALU-op encodings and control decode SHALL match the shared opcode definitions; BEQ sets out_branch, BNE sets out_branch and out_branch_ne; unknown opcodes decode to all controls 0, alu_op ALU_ADD.
REQ-018 out_imm SHALL be instr[IMM_W-1:0] sign-extended to DATA_W.
REQ-019 Register file: write on rising edge when wb_reg_write=1, wb_rd!=0, wb_rd<NREG; otherwise no write.
REQ-020 Reads of address 0 or address >=NREG SHALL return 0.
REQ-021 Write-through bypass: read address equal to wb_rd with a qualifying write that same cycle SHALL return wb_data.
REQ-022 Hazard = out_valid & out_mem_read & out_rd!=0 & (out_rd==instr[7:4] | out_rd==instr[3:0]).
REQ-023 in_ready = !halted & !flush & !hazard & (!out_valid | out_ready).
REQ-024 Accept (in_valid & in_ready): output register loads decode of instr, out_valid=1; latency exactly one clock.
REQ-025 No accept and (out_ready | !out_valid): out_valid<=0 (bubble); hazard with out_ready=1 SHALL insert exactly one bubble, then accept.
REQ-026 out_valid=1 and out_ready=0: all outputs SHALL hold unchanged.
REQ-027 flush=1: out_valid<=0 next edge, nothing accepted; flush priority over accept and hold; halted unchanged.
REQ-028 Accepting HALT sets halted=1 next edge; halted stays 1 until reset; bundle for HALT still delivered.
REQ-029 Control/field outputs SHALL be 0 whenever out_valid=0 after a bubble or flush.

Reset
REQ-030 rst=1 SHALL immediately clear all registers to 0, out_valid=0, halted=0, all out_* =0, out_alu_op=ALU_ADD; in_ready=0 while rst=1.
REQ-031 Reset asserted mid-transfer SHALL drop the pending bundle; first accept possible on first edge after rst deasserts.

Verification
REQ-032 Reset, write R3=0x0005 via WB, then ADD R1,R3,R3 accepted -> next cycle out_valid=1, out_rs1_data=out_rs2_data=0x0005, out_reg_write=1.
REQ-033 WB writes R2=0x1234 same cycle ADD R4,R2,R0 accepted -> out_rs1_data=0x1234 (bypass), out_rs2_data=0; WB to R0 -> R0 still reads 0.
REQ-034 LW R5 accepted, next instr ADD R6,R5,R1 with out_ready=1 -> in_ready=0 one cycle, one bubble, ADD then accepted.
REQ-035 out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0; out_ready=1 -> next instr accepted.
REQ-036 ADDI with instr[3:0]=0xF, DATA_W=16 -> out_imm=0xFFFF; DATA_W=8, NREG=8: read R9 -> 0, write R9 ignored.
REQ-037 HALT accepted -> out_halt=1 next cycle, halted=1, in_ready=0 permanently; flush during valid bundle -> out_valid=0 next edge; rst clears halted.
